// File: rtl/aes_inv_key_sched.sv
// AES-128 key schedule: expands a cipher key into rk0..rk10 (one round per cycle)
// and streams the stored round keys out in decryption order, rk10 first.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign y = SBOX[a];
endmodule

module aes_inv_key_sched #(
  parameter int NR = 10,
  parameter int KW = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [KW-1:0] key_in,
  input  logic          key_load,
  input  logic          rk_adv,
  input  logic          rk_rewind,
  output logic          key_busy,
  output logic          key_ready,
  output logic [KW-1:0] subkey,
  output logic [3:0]    rk_round,
  output logic          rk_last
);
  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  state_t        state;
  logic [KW-1:0] rk [0:NR];
  logic [3:0]    ptr, cnt;
  logic [7:0]    rcon, rcon_nxt;

  logic [KW-1:0]     prev;
  logic [3:0][31:0]  pw, nw;
  logic [31:0]       rot, sub, t;

  // pw[3] is w(4r-4), the most significant word; pw[0] is w(4r-1)
  assign prev = rk[cnt - 4'd1];
  assign pw   = prev;
  assign rot  = {pw[0][23:0], pw[0][31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.a(rot[g*8 +: 8]), .y(sub[g*8 +: 8]));
  end

  assign t     = sub ^ {rcon, 24'h0};
  assign nw[3] = pw[3] ^ t;
  assign nw[2] = pw[2] ^ nw[3];
  assign nw[1] = pw[1] ^ nw[2];
  assign nw[0] = pw[0] ^ nw[1];

  assign rcon_nxt = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
      ptr       <= '0;
      cnt       <= '0;
      rcon      <= 8'h01;
      key_busy  <= 1'b0;
      key_ready <= 1'b0;
    end else begin
      case (state)
        IDLE, READY: begin
          if (key_load) begin
            rk[0]     <= key_in;
            rcon      <= 8'h01;
            cnt       <= 4'd1;
            key_busy  <= 1'b1;
            key_ready <= 1'b0;
            state     <= EXPAND;
          end else if (state == READY) begin
            if (rk_rewind)             ptr <= 4'(NR);
            else if (rk_adv && ptr != 4'd0) ptr <= ptr - 4'd1;
          end
        end
        EXPAND: begin
          rk[cnt] <= nw;
          rcon    <= rcon_nxt;
          if (cnt == 4'(NR)) begin
            ptr       <= 4'(NR);
            key_busy  <= 1'b0;
            key_ready <= 1'b1;
            state     <= READY;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign subkey   = key_ready ? rk[ptr] : '0;
  assign rk_round = ptr;
  assign rk_last  = key_ready & (ptr == 4'd0);
endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Randomized self-check of aes_inv_key_sched against a key-expansion model whose
// S-box is derived from GF(2^8) inversion plus the affine map.

module tb_aes_inv_key_sched;
  logic         clk, rst_n;
  logic [127:0] key_in;
  logic         key_load, rk_adv, rk_rewind;
  logic         key_busy, key_ready, rk_last;
  logic [127:0] subkey;
  logic [3:0]   rk_round;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sb [0:255];
  logic [127:0] mrk [0:10];
  int           mptr;

  aes_inv_key_sched #(.NR(10), .KW(128)) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_load(key_load),
    .rk_adv(rk_adv), .rk_rewind(rk_rewind), .key_busy(key_busy),
    .key_ready(key_ready), .subkey(subkey), .rk_round(rk_round), .rk_last(rk_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int j = 0; j < 4; j++) w[j] = key[127 - 32*j -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++) mrk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic load_key(input logic [127:0] k);
    @(negedge clk);
    key_in = k; key_load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_load = 1'b0;
  endtask

  // Called just after the load edge; returns number of cycles until key_ready
  task automatic wait_ready(output int n);
    n = 0;
    while (!key_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!key_ready) chk("ready_timeout", 128'(key_ready), 128'd1);
  endtask

  task automatic chk_stream(input string tag);
    chk({tag, "_subkey"}, subkey, mrk[mptr]);
    chk({tag, "_round"}, 128'(rk_round), 128'(mptr));
    chk({tag, "_last"}, 128'(rk_last), 128'(mptr == 0));
  endtask

  task automatic step(input logic adv, input logic rew);
    rk_adv = adv; rk_rewind = rew;
    @(posedge clk);
    if (rew) mptr = 10;
    else if (adv && mptr > 0) mptr--;
    @(negedge clk);
    rk_adv = 1'b0; rk_rewind = 1'b0;
  endtask

  initial begin
    int n;
    logic [127:0] ka, kb;
    rst_n = 1'b0; key_in = '0; key_load = 1'b0; rk_adv = 1'b0; rk_rewind = 1'b0;
    build_sbox();
    chk("sbox_model_00", 128'(sb[0]), 128'h63);
    #12;
    chk("rst_busy", 128'(key_busy), 128'd0);
    chk("rst_ready", 128'(key_ready), 128'd0);
    chk("rst_subkey", subkey, 128'd0);
    chk("rst_round", 128'(rk_round), 128'd0);
    chk("rst_last", 128'(rk_last), 128'd0);
    @(negedge clk); rst_n = 1'b1;

    // FIPS-197 A.1 key, busy window exactly 10 cycles
    ka = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    model_expand(ka);
    load_key(ka);
    for (int i = 1; i <= 10; i++) begin
      chk($sformatf("busy_c%0d", i), {key_busy, key_ready}, 128'b10);
      @(negedge clk);
    end
    chk("done_flags", {key_busy, key_ready}, 128'b01);
    chk("fips_rk10", subkey, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    mptr = 10;
    chk_stream("a1_init");
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
    chk("fips_rk1", subkey, 128'ha0fafe1788542cb123a339392a6c7605);
    chk_stream("a1_rk1");
    step(1'b1, 1'b0);
    chk("fips_rk0", subkey, ka);
    chk("fips_last", 128'(rk_last), 128'd1);
    step(1'b1, 1'b0);
    chk("hold_round0", 128'(rk_round), 128'd0);
    chk_stream("a1_hold");

    // Second known key, then simultaneous adv+rewind at ptr=3
    kb = 128'h000102030405060708090a0b0c0d0e0f;
    model_expand(kb);
    load_key(kb);
    wait_ready(n);
    mptr = 10;
    chk("k2_rk10", subkey, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
    chk("k2_ptr3", 128'(rk_round), 128'd3);
    step(1'b1, 1'b1);
    chk("both_rewind", 128'(rk_round), 128'd10);
    chk_stream("k2_rew");

    // Random keys with random stream control
    for (int k = 0; k < 4; k++) begin
      logic [127:0] kr = {$urandom, $urandom, $urandom, $urandom};
      model_expand(kr);
      load_key(kr);
      wait_ready(n);
      chk($sformatf("rnd%0d_lat", k), 128'(n), 128'd10);
      mptr = 10;
      chk_stream($sformatf("rnd%0d_init", k));
      for (int c = 0; c < 25; c++) begin
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
        chk_stream($sformatf("rnd%0d_c%0d", k, c));
      end
    end

    // key_load during expansion is ignored
    model_expand(ka);
    load_key(ka);
    repeat (4) @(negedge clk);
    key_in = kb; key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    wait_ready(n);
    mptr = 10;
    chk("ignore_load_rk10", subkey, mrk[10]);

    // key_load in READY restarts with the new key
    model_expand(kb);
    load_key(kb);
    chk("reload_ready_drop", 128'(key_ready), 128'd0);
    wait_ready(n);
    chk("reload_lat", 128'(n), 128'd10);
    chk("reload_rk10", subkey, mrk[10]);

    // Asynchronous reset in mid-expansion
    load_key(ka);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 128'(key_busy), 128'd0);
    chk("arst_ready", 128'(key_ready), 128'd0);
    chk("arst_subkey", subkey, 128'd0);
    chk("arst_round", 128'(rk_round), 128'd0);
    @(negedge clk); rst_n = 1'b1;
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    chk("post_rst_ready", 128'(key_ready), 128'd0);
    chk("post_rst_round", 128'(rk_round), 128'd0);
    chk("post_rst_subkey", subkey, 128'd0);
    model_expand(ka);
    load_key(ka);
    wait_ready(n);
    mptr = 10;
    chk_stream("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
